// File: rtl/prbs_pkg.sv
// Shared opcodes, FSM state type and default geometry for the PRBS burst controller.
package prbs_pkg;

   localparam logic [1:0] OP_SEED  = 2'b00;
   localparam logic [1:0] OP_LEN   = 2'b01;
   localparam logic [1:0] OP_START = 2'b10;
   localparam logic [1:0] OP_ABORT = 2'b11;

   localparam int unsigned LFSR_W_DEF = 31;
   localparam int unsigned TAP_A_DEF  = 30;
   localparam int unsigned TAP_B_DEF  = 27;
   localparam int unsigned LEN_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/prbs31_core.sv
// Fibonacci LFSR register: shift-left, feedback of the two taps into bit 0.
module prbs31_core
   import prbs_pkg::*;
#(
   parameter int unsigned W     = LFSR_W_DEF,
   parameter int unsigned TAP_A = TAP_A_DEF,
   parameter int unsigned TAP_B = TAP_B_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         step,
   output logic [W-1:0] lfsr
);

   logic [W-1:0] lfsr_q;

   // LFSR state: load has priority over step, otherwise hold
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_q <= W'(1);
      end else if (load) begin
         lfsr_q <= load_val;
      end else if (step) begin
         lfsr_q <= {lfsr_q[W-2:0], lfsr_q[TAP_A] ^ lfsr_q[TAP_B]};
      end
   end

   assign lfsr = lfsr_q;

endmodule

// File: rtl/prbs_burst_ctrl.sv
// Command-driven burst controller sequencing a PRBS31 LFSR datapath.
module prbs_burst_ctrl
   import prbs_pkg::*;
#(
   parameter int unsigned LFSR_W = LFSR_W_DEF,
   parameter int unsigned TAP_A  = TAP_A_DEF,
   parameter int unsigned TAP_B  = TAP_B_DEF,
   parameter int unsigned LEN_W  = LEN_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic       bit_out,
   output logic       bit_valid,
   output logic       busy,
   output logic       done,
   output logic       err
);

   // Masking the whole state keeps every LFSR bit referenced; it reduces to lfsr[TAP_A].
   localparam logic [LFSR_W-1:0] TAP_MASK = LFSR_W'(1) << TAP_A;

   state_t            state_q, state_n;
   logic [LFSR_W-1:0] seed_q;
   logic [LFSR_W-1:0] lfsr;
   logic [LEN_W-1:0]  len_q, remaining_q;
   logic              load, step, seed_we, len_we, err_n;
   logic              err_q, ready_q;

   prbs31_core #(
      .W     (LFSR_W),
      .TAP_A (TAP_A),
      .TAP_B (TAP_B)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (seed_q),
      .step     (step),
      .lfsr     (lfsr)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Next-state and command decode; abort in RUN wins over the final step
   always_comb begin
      state_n = state_q;
      load    = 1'b0;
      step    = 1'b0;
      seed_we = 1'b0;
      len_we  = 1'b0;
      err_n   = 1'b0;
      case (state_q)
         RUN: begin
            if (cmd_valid && (cmd_op == OP_ABORT)) begin
               state_n = IDLE;
            end else begin
               step  = 1'b1;
               err_n = cmd_valid;
               if (remaining_q == LEN_W'(1)) begin
                  state_n = DONE;
               end
            end
         end
         default: begin
            state_n = IDLE;
            if (cmd_valid) begin
               case (cmd_op)
                  OP_SEED: seed_we = 1'b1;
                  OP_LEN:  len_we  = 1'b1;
                  OP_START: begin
                     if (seed_q == '0) begin
                        err_n = 1'b1;
                     end else begin
                        load    = 1'b1;
                        state_n = (len_q == '0) ? DONE : RUN;
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   // Seed/length shift registers, remaining counter, registered strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seed_q      <= LFSR_W'(1);
         len_q       <= '0;
         remaining_q <= '0;
         err_q       <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         err_q   <= err_n;
         if (seed_we) begin
            seed_q <= {seed_q[LFSR_W-9:0], cmd_data};
         end
         if (len_we) begin
            len_q <= {len_q[LEN_W-9:0], cmd_data};
         end
         if (load) begin
            remaining_q <= len_q;
         end else if (step) begin
            remaining_q <= remaining_q - LEN_W'(1);
         end
      end
   end

   // Output decode from registered state only
   always_comb begin
      busy      = (state_q == RUN);
      bit_valid = busy;
      done      = (state_q == DONE);
      err       = err_q;
      cmd_ready = ready_q;
      bit_out   = busy & (|(lfsr & TAP_MASK));
   end

endmodule

// File: doc/prbs_burst_ctrl.md
# prbs_burst_ctrl

Command-driven controller for a 31-bit PRBS31 Fibonacci LFSR (taps at bits 30 and 27, shift-left, feedback into bit 0, output taken from bit 30). The controller accepts byte-wide commands that set a seed and a burst length, starts a burst, and aborts one. It emits exactly the requested number of sequence bits with a valid strobe, then pulses done. It sits between the top-level pin logic and the LFSR datapath, which it owns and sequences.

## Interface
Parameters:
- LFSR_W, 31, LFSR width.
- TAP_A, 30, first feedback tap and output bit.
- TAP_B, 27, second feedback tap.
- LEN_W, 16, burst-length counter width.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  always 1 out of reset; a command is accepted on any cycle with cmd_valid high.
- cmd_op  in  2  opcode: 00 SEED_BYTE, 01 LEN_BYTE, 10 START, 11 ABORT.
- cmd_data  in  8  payload for SEED_BYTE and LEN_BYTE.
- bit_out  out  1  current sequence bit.
- bit_valid  out  1  bit_out is a burst bit.
- busy  out  1  high when state is RUN.
- done  out  1  one-cycle pulse when a burst completes normally.
- err  out  1  one-cycle pulse on an illegal command.

## Operation
- States: IDLE, RUN, DONE.
- Reset values:
  - State IDLE.
  - seed = 31'd1, len = 0, lfsr = 31'd1, remaining = 0.
  - bit_out, bit_valid, busy, done and err all 0.
- SEED_BYTE, accepted in IDLE or DONE: seed <= {seed[22:0], cmd_data}[30:0]. Four writes load a full seed, most significant byte first; the top bit of the first byte is discarded.
- LEN_BYTE, accepted in IDLE or DONE: len <= {len[7:0], cmd_data}.
- START, accepted in IDLE or DONE:
  - If seed == 0: err pulses, state stays IDLE, and the LFSR is untouched.
  - Otherwise: lfsr <= seed, remaining <= len, and state goes to RUN. If len == 0, state goes to DONE instead.
- RUN, every cycle:
  - bit_valid = 1 and bit_out = lfsr[30].
  - Step: lfsr <= {lfsr[29:0], lfsr[30]^lfsr[27]}, and remaining decrements.
  - When remaining == 1 on a step, next state is DONE.
- DONE lasts one cycle with done = 1, then returns to IDLE. It accepts commands exactly like IDLE; a START accepted in DONE goes straight back to RUN.
- ABORT:
  - In RUN: next state is IDLE, no done pulse, and lfsr holds its current value.
  - In IDLE or DONE: no effect and no err.
- SEED_BYTE, LEN_BYTE or START received during RUN: dropped and err pulses. The burst continues unaffected.
- ABORT in the same cycle as the last burst bit: abort wins, so no done pulse follows.
- Outside RUN the LFSR is frozen.
- seed and len persist across bursts; a repeated START replays an identical sequence.

## Timing
- START accepted at cycle T with len = N > 0:
  - bit_valid is high on cycles T+1 through T+N.
  - Bit k (0-based) equals bit 30 of the seed after k steps.
  - done is high on cycle T+N+1; busy is high on cycles T+1 through T+N.
- With len = 0: done is high on cycle T+1 and bit_valid is never asserted.
- err is high on the cycle after the offending command is accepted.
- All outputs are registered; there is no combinational path from cmd_* to any output.
- rst_n low mid-burst: on the next edge every register returns to its reset value, and bit_valid and busy drop.

## Structure
- Package prbs_pkg holds:
  - Opcode localparams OP_SEED, OP_LEN, OP_START, OP_ABORT.
  - The state enum (IDLE, RUN, DONE).
  - Default widths and tap indices.
- Sub-module prbs31_core contains the LFSR register with `load`, `load_val` and `step` inputs. load has priority over step. It has a synchronous active-low reset to 31'd1 and exposes the full state.
- The controller (FSM, seed and length shift registers, remaining counter, output registers) lives in prbs_burst_ctrl.

## Test plan
- Reset, then START with the default seed 1 and len 31: bit_valid is high for 31 cycles, bits are 30 zeros followed by a 1, and done pulses on cycle T+32.
- SEED_BYTE 0x12, 0x34, 0x56, 0x78, then LEN_BYTE 0x00, 0x40, then START: 64 bits match a software PRBS31 model seeded with 0x12345678 (top bit masked). A second START replays the identical 64 bits.
- SEED_BYTE 0x00 four times, then START: err pulses once, busy stays 0, and no bit_valid appears.
- Load len 0x0100, START, then ABORT on the 10th valid bit: exactly 10 bits are emitted, busy falls, and there is no done pulse. A START during the run also produces an err pulse while bits continue.
- len 0 with START: done is high on cycle T+1 and bit_valid is never set. A START issued during that DONE cycle with len 5 yields 5 bits.
- Drop rst_n for one cycle during a burst: on the next edge all outputs are 0 and state is IDLE. A later START with no new seed uses seed 1.
